// File: rtl/arp_requester.sv
// -----------------------------------------------------------------------------
// arp_requester
//
// ARP initiator. Accepts a target-IP resolve request, transmits a 7-word ARP
// request on a 32-bit TX stream, then watches the RX stream for the matching
// ARP reply and reports the resolved MAC. Without a reply it retransmits on
// timeout and, once the retries are used up, signals failure.
//
// Optional build macro:
//   ARP_CACHE_EN - single-entry {valid, ip, mac} cache; a request that hits
//                  the cache completes without transmitting.
//
// Parameters:
//   TIMEOUT_CYCLES - cycles to wait for a reply per attempt
//   TMO_WIDTH      - timeout counter width (TIMEOUT_CYCLES < 2**TMO_WIDTH)
//   MAX_RETRIES    - retransmissions after the first attempt before failing
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid/i_req_ip, o_req_ready
//                       resolve request handshake (ready only in IDLE)
//   i_local_mac/ip      own addresses, sampled at the start of each frame
//   o_tx_data/valid/last, i_tx_ready
//                       ARP request stream, last on word 6
//   i_rx_data/valid/last, o_rx_ready
//                       received ARP stream, always accepted
//   o_resolved_valid    1-cycle success pulse
//   o_resolved_mac/ip   last resolved MAC and the IP it belongs to
//   o_timeout           1-cycle failure pulse
//   o_busy              high whenever not IDLE
//   o_retry_cnt         retries used by the current request
// -----------------------------------------------------------------------------
module arp_requester #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TMO_WIDTH      = 20,
   parameter int MAX_RETRIES    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   input  logic [31:0] i_req_ip,
   output logic        o_req_ready,
   input  logic [47:0] i_local_mac,
   input  logic [31:0] i_local_ip,
   output logic [31:0] o_tx_data,
   output logic        o_tx_valid,
   output logic        o_tx_last,
   input  logic        i_tx_ready,
   input  logic [31:0] i_rx_data,
   input  logic        i_rx_valid,
   input  logic        i_rx_last,
   output logic        o_rx_ready,
   output logic        o_resolved_valid,
   output logic [47:0] o_resolved_mac,
   output logic [31:0] o_resolved_ip,
   output logic        o_timeout,
   output logic        o_busy,
   output logic [1:0]  o_retry_cnt
);

   localparam logic [TMO_WIDTH-1:0] TMO_INIT = TMO_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_WAIT,
      S_DONE,
      S_FAIL
   } state_t;

   state_t state, state_nxt;

   logic [31:0]          target_ip;
   logic [47:0]          tx_mac;
   logic [31:0]          tx_ip;
   logic [2:0]           tx_idx;
   logic [TMO_WIDTH-1:0] timer;
   logic [1:0]           retry_cnt;
   logic [47:0]          resolved_mac;
   logic [31:0]          resolved_ip;

   // RX parser state
   logic [2:0]           rx_cnt;
   logic                 rx_long;
   logic                 rx_good;
   logic [31:0]          rx_sha_hi;
   logic [15:0]          rx_sha_lo;

   logic                 req_fire;
   logic                 tx_fire;
   logic                 tx_done;
   logic                 timer_zero;
   logic                 retry_ok;
   logic                 rx_word_ok;
   logic                 rx_match;
   logic                 cache_hit;
   logic [31:0]          tx_word;

`ifdef ARP_CACHE_EN
   logic                 cache_valid;
   logic [31:0]          cache_ip;
   logic [47:0]          cache_mac;

   assign cache_hit = cache_valid && (i_req_ip == cache_ip);
`else
   assign cache_hit = 1'b0;
`endif

   assign req_fire   = i_req_valid && (state == S_IDLE);
   assign tx_fire    = (state == S_TX) && i_tx_ready;
   assign tx_done    = tx_fire && (tx_idx == 3'd6);
   assign timer_zero = (timer == '0);
   assign retry_ok   = (32'(retry_cnt) < MAX_RETRIES);

   // Per-word header/SPA checks; SPA straddles words 3 and 4
   always_comb begin
      rx_word_ok = 1'b1;
      case (rx_cnt)
         3'd0:    rx_word_ok = (i_rx_data == 32'h0001_0800);
         3'd1:    rx_word_ok = (i_rx_data == 32'h0604_0002);
         3'd3:    rx_word_ok = (i_rx_data[15:0]  == target_ip[31:16]);
         3'd4:    rx_word_ok = (i_rx_data[31:16] == target_ip[15:0]);
         default: rx_word_ok = 1'b1;
      endcase
   end

   // Evaluated on the W6 beat so DONE follows one cycle after the last beat
   assign rx_match = (state == S_WAIT) && i_rx_valid && i_rx_last &&
                     !rx_long && (rx_cnt == 3'd6) && rx_good &&
                     (i_rx_data == i_local_ip);

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req_fire) state_nxt = cache_hit ? S_DONE : S_TX;
         S_TX:   if (tx_done)  state_nxt = S_WAIT;
         S_WAIT: begin
            // A match in the expiry cycle still counts as success
            if (rx_match)        state_nxt = S_DONE;
            else if (timer_zero) state_nxt = retry_ok ? S_TX : S_FAIL;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_FAIL:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Main control / transmit / timer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         target_ip    <= '0;
         tx_mac       <= '0;
         tx_ip        <= '0;
         tx_idx       <= '0;
         timer        <= '0;
         retry_cnt    <= '0;
         resolved_mac <= '0;
         resolved_ip  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (req_fire) begin
                  target_ip <= i_req_ip;
                  retry_cnt <= '0;
                  tx_mac    <= i_local_mac;
                  tx_ip     <= i_local_ip;
                  tx_idx    <= '0;
`ifdef ARP_CACHE_EN
                  if (cache_hit) begin
                     resolved_mac <= cache_mac;
                     resolved_ip  <= cache_ip;
                  end
`endif
               end
            end
            S_TX: begin
               if (tx_fire) begin
                  tx_idx <= tx_done ? 3'd0 : tx_idx + 3'd1;
                  if (tx_done) timer <= TMO_INIT;
               end
            end
            S_WAIT: begin
               timer <= timer - TMO_ONE;
               if (rx_match) begin
                  // Visible together with the o_resolved_valid pulse in DONE
                  resolved_mac <= {rx_sha_hi, rx_sha_lo};
                  resolved_ip  <= target_ip;
               end else if (timer_zero && retry_ok) begin
                  retry_cnt <= retry_cnt + 2'd1;
                  tx_mac    <= i_local_mac;
                  tx_ip     <= i_local_ip;
                  tx_idx    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // RX parser: runs in every state, last beat always restarts the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt    <= '0;
         rx_long   <= 1'b0;
         rx_good   <= 1'b0;
         rx_sha_hi <= '0;
         rx_sha_lo <= '0;
      end else if (i_rx_valid) begin
         rx_good <= (rx_cnt == 3'd0) ? rx_word_ok : (rx_good && rx_word_ok);
         if (rx_cnt == 3'd2) rx_sha_hi <= i_rx_data;
         if (rx_cnt == 3'd3) rx_sha_lo <= i_rx_data[31:16];
         if (i_rx_last) begin
            rx_cnt  <= '0;
            rx_long <= 1'b0;
         end else if (rx_cnt == 3'd6) begin
            // Frame runs past word 6 without last: poison it until last
            rx_long <= 1'b1;
         end else begin
            rx_cnt <= rx_cnt + 3'd1;
         end
      end
   end

`ifdef ARP_CACHE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_ip    <= '0;
         cache_mac   <= '0;
      end else if (state == S_DONE) begin
         cache_valid <= 1'b1;
         cache_ip    <= resolved_ip;
         cache_mac   <= resolved_mac;
      end
   end
`endif

   // Request word mux; fields come from registers so data holds while stalled
   always_comb begin
      tx_word = '0;
      case (tx_idx)
         3'd0:    tx_word = 32'h0001_0800;
         3'd1:    tx_word = 32'h0604_0001;
         3'd2:    tx_word = tx_mac[47:16];
         3'd3:    tx_word = {tx_mac[15:0], tx_ip[31:16]};
         3'd4:    tx_word = {tx_ip[15:0], 16'h0000};
         3'd5:    tx_word = 32'h0000_0000;
         3'd6:    tx_word = target_ip;
         default: tx_word = '0;
      endcase
   end

   assign o_req_ready      = (state == S_IDLE);
   assign o_busy           = (state != S_IDLE);
   assign o_tx_valid       = (state == S_TX);
   assign o_tx_last        = o_tx_valid && (tx_idx == 3'd6);
   assign o_tx_data        = o_tx_valid ? tx_word : 32'h0;
   assign o_rx_ready       = 1'b1;
   assign o_resolved_valid = (state == S_DONE);
   assign o_timeout        = (state == S_FAIL);
   assign o_resolved_mac   = resolved_mac;
   assign o_resolved_ip    = resolved_ip;
   assign o_retry_cnt      = retry_cnt;

endmodule

// File: tb/tb_arp_requester.sv
// -----------------------------------------------------------------------------
// tb_arp_requester
//
// Self-checking bench for arp_requester (TIMEOUT_CYCLES = 50). Expected TX
// words are queued when a request is issued and popped by a monitor as beats
// are accepted. Define ARP_CACHE_EN to include the cache scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arp_requester;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0;
   logic [31:0] i_req_ip = '0;
   logic        o_req_ready;
   logic [47:0] i_local_mac = '0;
   logic [31:0] i_local_ip = '0;
   logic [31:0] o_tx_data;
   logic        o_tx_valid;
   logic        o_tx_last;
   logic        i_tx_ready = 1'b1;
   logic [31:0] i_rx_data = '0;
   logic        i_rx_valid = 1'b0;
   logic        i_rx_last = 1'b0;
   logic        o_rx_ready;
   logic        o_resolved_valid;
   logic [47:0] o_resolved_mac;
   logic [31:0] o_resolved_ip;
   logic        o_timeout;
   logic        o_busy;
   logic [1:0]  o_retry_cnt;

   arp_requester #(
      .TIMEOUT_CYCLES(50),
      .TMO_WIDTH(20),
      .MAX_RETRIES(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_ip(i_req_ip), .o_req_ready(o_req_ready),
      .i_local_mac(i_local_mac), .i_local_ip(i_local_ip),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last),
      .i_tx_ready(i_tx_ready),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_rx_last(i_rx_last),
      .o_rx_ready(o_rx_ready),
      .o_resolved_valid(o_resolved_valid), .o_resolved_mac(o_resolved_mac),
      .o_resolved_ip(o_resolved_ip), .o_timeout(o_timeout),
      .o_busy(o_busy), .o_retry_cnt(o_retry_cnt)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [32:0] exp_q[$];
   int          tx_beats = 0;
   int          rv_pulses = 0;
   int          to_pulses = 0;
   logic        stall_pending = 1'b0;
   logic [32:0] stall_word = '0;

   // TX monitor / scoreboard, sampled on the falling edge
   initial begin
      logic [32:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (o_tx_valid && stall_pending) begin
               vectors++;
               if ({o_tx_last, o_tx_data} !== stall_word) begin
                  miscompares++;
                  $display("FAIL tx_stall_hold got %h want %h", {o_tx_last, o_tx_data}, stall_word);
               end
            end
            stall_pending = 1'b0;
            if (o_tx_valid && i_tx_ready) begin
               tx_beats++;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL tx_unexpected got %h want no beat", {o_tx_last, o_tx_data});
               end else begin
                  exp = exp_q.pop_front();
                  if ({o_tx_last, o_tx_data} !== exp) begin
                     miscompares++;
                     $display("FAIL tx_word got %h want %h", {o_tx_last, o_tx_data}, exp);
                  end
               end
            end else if (o_tx_valid) begin
               stall_pending = 1'b1;
               stall_word    = {o_tx_last, o_tx_data};
            end
            if (o_resolved_valid) rv_pulses++;
            if (o_timeout)        to_pulses++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [31:0] ip);
      exp_q.push_back({1'b0, 32'h0001_0800});
      exp_q.push_back({1'b0, 32'h0604_0001});
      exp_q.push_back({1'b0, i_local_mac[47:16]});
      exp_q.push_back({1'b0, i_local_mac[15:0], i_local_ip[31:16]});
      exp_q.push_back({1'b0, i_local_ip[15:0], 16'h0000});
      exp_q.push_back({1'b0, 32'h0000_0000});
      exp_q.push_back({1'b1, ip});
   endtask

   // Returns one cycle after the handshake, at posedge + 1
   task automatic request(input logic [31:0] ip, input bit expect_tx);
      int k = 0;
      tick();
      while (!o_req_ready && k < 300) begin
         tick();
         k++;
      end
      if (!o_req_ready) begin
         vectors++; miscompares++;
         $display("FAIL req_ready_wait got 0 want 1");
      end
      drive_edge();
      i_req_valid = 1'b1;
      i_req_ip    = ip;
      if (expect_tx) push_frame(ip);
      drive_edge();
      i_req_valid = 1'b0;
   endtask

   task automatic wait_beats(input int target);
      int k = 0;
      while (tx_beats < target && k < 500) begin
         tick();
         k++;
      end
      if (tx_beats < target) begin
         vectors++; miscompares++;
         $display("FAIL tx_beat_wait got %0d want %0d", tx_beats, target);
      end
   endtask

   task automatic send_frame(input logic [31:0] w [7], input int n);
      for (int i = 0; i < n; i++) begin
         drive_edge();
         i_rx_valid = 1'b1;
         i_rx_data  = w[i];
         i_rx_last  = (i == n - 1);
      end
      drive_edge();
      i_rx_valid = 1'b0;
      i_rx_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      vectors++;
      if ({o_req_ready, o_rx_ready, o_tx_valid, o_tx_last, o_busy, o_resolved_valid, o_timeout, o_retry_cnt} !== 9'b110000000) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 110000000",
                  {o_req_ready, o_rx_ready, o_tx_valid, o_tx_last, o_busy, o_resolved_valid, o_timeout, o_retry_cnt});
      end
      vectors++;
      if ({o_tx_data, o_resolved_mac, o_resolved_ip} !== 112'h0) begin
         miscompares++;
         $display("FAIL reset_data got %h want 0", {o_tx_data, o_resolved_mac, o_resolved_ip});
      end
   endtask

   task automatic test_basic_request();
      int base = tx_beats;
      i_local_mac = 48'h000A_3500_0102;
      i_local_ip  = 32'hC0A8_010A;
      i_tx_ready  = 1'b1;
      request(32'hC0A8_0114, 1'b1);
      tick();
      vectors++;
      if ({o_busy, o_tx_valid, o_req_ready} !== 3'b110) begin
         miscompares++;
         $display("FAIL basic_busy got %b want 110", {o_busy, o_tx_valid, o_req_ready});
      end
      wait_beats(base + 7);
      tick();
      vectors++;
      if ({o_busy, o_tx_valid, exp_q.size() == 0} !== 3'b101) begin
         miscompares++;
         $display("FAIL basic_wait_state got %b want 101", {o_busy, o_tx_valid, exp_q.size() == 0});
      end
   endtask

   task automatic test_bad_replies();
      logic [31:0] f [7];
      int rv0 = rv_pulses;
      f = '{32'h0001_0800, 32'h0604_0002, 32'h0011_2233, 32'h4455_C0A8,
            32'h0115_000A, 32'h3500_0102, 32'hC0A8_010A};
      send_frame(f, 7);
      f[4] = 32'h0114_000A;
      send_frame(f, 6);
      f[1] = 32'h0604_0001;
      send_frame(f, 7);
      tick(); tick();
      vectors++;
      if (rv_pulses !== rv0) begin
         miscompares++;
         $display("FAIL bad_reply_resolved got %0d want %0d", rv_pulses, rv0);
      end
      vectors++;
      if ({o_busy, o_retry_cnt} !== 3'b100) begin
         miscompares++;
         $display("FAIL bad_reply_state got %b want 100", {o_busy, o_retry_cnt});
      end
   endtask

   task automatic test_reply_resolution();
      logic [31:0] f [7];
      f = '{32'h0001_0800, 32'h0604_0002, 32'h0011_2233, 32'h4455_C0A8,
            32'h0114_000A, 32'h3500_0102, 32'hC0A8_010A};
      for (int i = 0; i < 7; i++) begin
         drive_edge();
         i_rx_valid = 1'b1;
         i_rx_data  = f[i];
         i_rx_last  = (i == 6);
      end
      tick();
      vectors++;
      if (o_resolved_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL resolve_early got %b want 0", o_resolved_valid);
      end
      drive_edge();
      i_rx_valid = 1'b0;
      i_rx_last  = 1'b0;
      tick();
      vectors++;
      if ({o_resolved_valid, o_resolved_mac, o_resolved_ip} !== {1'b1, 48'h0011_2233_4455, 32'hC0A8_0114}) begin
         miscompares++;
         $display("FAIL resolve_pulse got %h want %h", {o_resolved_valid, o_resolved_mac, o_resolved_ip},
                  {1'b1, 48'h0011_2233_4455, 32'hC0A8_0114});
      end
      tick();
      vectors++;
      if ({o_resolved_valid, o_busy, o_req_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL resolve_end got %b want 001", {o_resolved_valid, o_busy, o_req_ready});
      end
   endtask

`ifdef ARP_CACHE_EN
   task automatic test_cache();
      int base = tx_beats;
      request(32'hC0A8_0114, 1'b0);
      tick();
      vectors++;
      if ({o_resolved_valid, o_resolved_mac, o_resolved_ip} !== {1'b1, 48'h0011_2233_4455, 32'hC0A8_0114}) begin
         miscompares++;
         $display("FAIL cache_hit got %h want %h", {o_resolved_valid, o_resolved_mac, o_resolved_ip},
                  {1'b1, 48'h0011_2233_4455, 32'hC0A8_0114});
      end
      repeat (5) tick();
      vectors++;
      if (tx_beats !== base) begin
         miscompares++;
         $display("FAIL cache_tx_beats got %0d want %0d", tx_beats, base);
      end
   endtask
`endif

   // Stalled TX, then a reply whose last beat lands in the timer-expiry cycle
   task automatic test_backpressure_race();
      logic [31:0] f [7];
      int base = tx_beats;
      int to0  = to_pulses;
      int k    = 0;
      f = '{32'h0001_0800, 32'h0604_0002, 32'h6677_8899, 32'hAABB_C0A8,
            32'h0120_000A, 32'h3500_0102, 32'hC0A8_010A};
      i_tx_ready = 1'b0;
      request(32'hC0A8_0120, 1'b1);
      forever begin
         tick();
         if (tx_beats >= base + 7 || k >= 100) break;
         drive_edge();
         i_tx_ready = ~i_tx_ready;
         k++;
      end
      vectors++;
      if (tx_beats !== base + 7) begin
         miscompares++;
         $display("FAIL bp_tx_beats got %0d want %0d", tx_beats, base + 7);
      end
      // Now in the last TX cycle; the next posedge starts WAIT cycle 0
      repeat (44) @(posedge clk);
      i_tx_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive_edge();
         i_rx_valid = 1'b1;
         i_rx_data  = f[i];
         i_rx_last  = (i == 6);
      end
      drive_edge();
      i_rx_valid = 1'b0;
      i_rx_last  = 1'b0;
      tick();
      vectors++;
      if ({o_resolved_valid, o_resolved_mac, o_resolved_ip, o_retry_cnt} !==
          {1'b1, 48'h6677_8899_AABB, 32'hC0A8_0120, 2'd0}) begin
         miscompares++;
         $display("FAIL race_resolve got %h want %h", {o_resolved_valid, o_resolved_mac, o_resolved_ip, o_retry_cnt},
                  {1'b1, 48'h6677_8899_AABB, 32'hC0A8_0120, 2'd0});
      end
      repeat (4) tick();
      vectors++;
      if (tx_beats !== base + 7 || to_pulses !== to0) begin
         miscompares++;
         $display("FAIL race_no_retry got beats %0d timeouts %0d want beats %0d timeouts %0d",
                  tx_beats, to_pulses, base + 7, to0);
      end
   endtask

   task automatic test_timeout();
      int base = tx_beats;
      int to0  = to_pulses;
      int rv0  = rv_pulses;
      int k    = 0;
      logic [1:0] prev;
      logic [1:0] seq[$];
      request(32'hC0A8_0199, 1'b1);
      repeat (3) push_frame(32'hC0A8_0199);
      prev = 2'd0;
      while (to_pulses == to0 && k < 1000) begin
         tick();
         if (o_retry_cnt !== prev) begin
            seq.push_back(o_retry_cnt);
            prev = o_retry_cnt;
         end
         k++;
      end
      repeat (3) tick();
      vectors++;
      if (seq.size() != 3 || seq[0] !== 2'd1 || seq[1] !== 2'd2 || seq[2] !== 2'd3) begin
         miscompares++;
         $display("FAIL retry_sequence got %0d steps ending %0d want 3 steps 1,2,3",
                  seq.size(), (seq.size() > 0) ? seq[seq.size()-1] : 2'd0);
      end
      vectors++;
      if (tx_beats - base !== 28) begin
         miscompares++;
         $display("FAIL timeout_frames got %0d beats want 28", tx_beats - base);
      end
      vectors++;
      if (to_pulses - to0 !== 1 || rv_pulses !== rv0) begin
         miscompares++;
         $display("FAIL timeout_pulses got to %0d rv %0d want to 1 rv 0", to_pulses - to0, rv_pulses - rv0);
      end
      vectors++;
      if ({o_resolved_mac, o_resolved_ip, o_busy} !== {48'h6677_8899_AABB, 32'hC0A8_0120, 1'b0}) begin
         miscompares++;
         $display("FAIL timeout_resolved_kept got %h want %h", {o_resolved_mac, o_resolved_ip, o_busy},
                  {48'h6677_8899_AABB, 32'hC0A8_0120, 1'b0});
      end
   endtask

   task automatic test_midframe_reset();
      int base = tx_beats;
      request(32'hC0A8_0140, 1'b1);
      wait_beats(base + 4);
      // Word 3 is on the bus in this cycle
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_req_ready, o_rx_ready, o_tx_valid, o_tx_last, o_busy, o_resolved_valid, o_timeout, o_retry_cnt} !== 9'b110000000) begin
         miscompares++;
         $display("FAIL midreset_ctrl got %b want 110000000",
                  {o_req_ready, o_rx_ready, o_tx_valid, o_tx_last, o_busy, o_resolved_valid, o_timeout, o_retry_cnt});
      end
      vectors++;
      if ({o_tx_data, o_resolved_mac, o_resolved_ip} !== 112'h0) begin
         miscompares++;
         $display("FAIL midreset_data got %h want 0", {o_tx_data, o_resolved_mac, o_resolved_ip});
      end
      exp_q.delete();
      drive_edge();
      rst_n = 1'b1;
      tick(); tick();
      vectors++;
      if ({o_req_ready, o_tx_valid, o_busy, o_resolved_ip} !== {3'b100, 32'h0}) begin
         miscompares++;
         $display("FAIL postreset_idle got %h want %h", {o_req_ready, o_tx_valid, o_busy, o_resolved_ip}, {3'b100, 32'h0});
      end
   endtask

   initial begin
      test_reset();
      test_basic_request();
      test_bad_replies();
      test_reply_resolution();
`ifdef ARP_CACHE_EN
      test_cache();
`endif
      test_backpressure_race();
      test_timeout();
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
